// File: rtl/bkg_scroll_ctrl.sv
// Background bank controller: scrolled read addressing, frame-synchronous bank select and
// tear-free loader write arbitration. Define BKG_SCROLL_CLAMP_EN to saturate scroll instead of wrapping.
module bkg_scroll_ctrl #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 160,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              disp_en,
  input  logic              vblank,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_step,
  input  logic              bank_req,
  input  logic [1:0]        bank_req_id,
  input  logic              wr_req,
  input  logic [1:0]        wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              wr_ack,
  output logic [3:0]        we,
  output logic [ADDR_W-1:0] write_address,
  output logic [23:0]       data_In,
  output logic [ADDR_W-1:0] read_address,
  output logic [1:0]        bkg_sel,
  input  logic [23:0]       pix_in,
  output logic [23:0]       pix_out,
  output logic              pix_valid
);
`ifdef BKG_SCROLL_CLAMP_EN
  localparam logic [7:0] SCROLL_MAX = 8'(IMG_H - (480 >> SCALE_SHIFT));
`else
  localparam logic [7:0] IMG_H_B = 8'(IMG_H);
`endif

  typedef enum logic {W_IDLE, W_WRITE} wstate_t;

  logic [7:0]        scroll_row_reg;
  logic [7:0]        scroll_row_next;
  logic [7:0]        scroll_sum;
  logic [1:0]        pending_id_reg;
  logic              pending_flag_reg;
  logic [9:0]        src_row;
  logic [9:0]        src_col;
  logic [9:0]        row_sum;
  logic [9:0]        row_wrap;
  logic [ADDR_W-1:0] rd_addr_next;
  logic              disp_d1_reg;
  logic              disp_d2_reg;
  wstate_t           wstate_reg;
  logic              wr_eligible;
  logic [3:0]        bank_onehot;

  // Scroll advance; 8 bits is enough for (IMG_H-1) + 15.
  assign scroll_sum = scroll_row_reg + {4'd0, scroll_step};

  always_comb begin
    scroll_row_next = scroll_sum;
`ifdef BKG_SCROLL_CLAMP_EN
    if (scroll_sum >= SCROLL_MAX) scroll_row_next = SCROLL_MAX;
`else
    if (scroll_sum >= IMG_H_B) scroll_row_next = scroll_sum - IMG_H_B;
`endif
  end

  // A pending or same-cycle bank request wins over the scroll increment at frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scroll_row_reg   <= '0;
      bkg_sel          <= '0;
      pending_id_reg   <= '0;
      pending_flag_reg <= 1'b0;
    end else if (frame_start && (pending_flag_reg || bank_req)) begin
      bkg_sel          <= bank_req ? bank_req_id : pending_id_reg;
      scroll_row_reg   <= '0;
      pending_flag_reg <= 1'b0;
    end else begin
      if (frame_start && scroll_en) scroll_row_reg <= scroll_row_next;
      if (bank_req) begin
        pending_id_reg   <= bank_req_id;
        pending_flag_reg <= 1'b1;
      end
    end
  end

  assign src_row = DrawY >> SCALE_SHIFT;
  assign src_col = DrawX >> SCALE_SHIFT;
  assign row_sum = src_row + {2'd0, scroll_row_reg};

`ifdef BKG_SCROLL_CLAMP_EN
  assign row_wrap = row_sum;
`else
  assign row_wrap = (row_sum >= 10'(IMG_H)) ? row_sum - 10'(IMG_H) : row_sum;
`endif

  assign rd_addr_next = ADDR_W'(row_wrap) * ADDR_W'(IMG_W) + ADDR_W'(src_col);

  // Address register, then one cycle of RAM latency, then the output register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      disp_d1_reg  <= 1'b0;
      disp_d2_reg  <= 1'b0;
      pix_out      <= '0;
      pix_valid    <= 1'b0;
    end else begin
      read_address <= rd_addr_next;
      disp_d1_reg  <= disp_en;
      disp_d2_reg  <= disp_d1_reg;
      pix_out      <= disp_d2_reg ? pix_in : '0;
      pix_valid    <= disp_d2_reg;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign bank_onehot[gi] = (wr_bank == 2'(gi));
  end

  // The shown bank and the bank about to be shown are only writable during vblank.
  assign wr_eligible = wr_req && (vblank || (wr_bank != bkg_sel &&
                       !(pending_flag_reg && wr_bank == pending_id_reg)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wstate_reg    <= W_IDLE;
      we            <= '0;
      wr_ack        <= 1'b0;
      write_address <= '0;
      data_In       <= '0;
    end else if (wstate_reg == W_IDLE) begin
      if (wr_eligible) begin
        wstate_reg    <= W_WRITE;
        we            <= bank_onehot;
        wr_ack        <= 1'b1;
        write_address <= wr_addr;
        data_In       <= wr_data;
      end
    end else begin
      wstate_reg <= W_IDLE;
      we         <= '0;
      wr_ack     <= 1'b0;
    end
  end
endmodule

// File: doc/bkg_scroll_ctrl.md
Name: bkg_scroll_ctrl

Overview:
Controller for the four 160x160 background RAM banks (BKG1..BKG4, 24-bit pixels, 15-bit addresses). It turns VGA DrawX/DrawY into pipelined read addresses with vertical scroll, and selects the displayed bank. It also arbitrates a single loader write port so the displayed bank is only written during vertical blanking, which prevents tearing. It sits between the VGA controller, the game-state logic (scroll speed, level bank) and the bank RAMs.

Parameters:
IMG_W, 160, image width in pixels
IMG_H, 160, image height in rows
SCALE_SHIFT, 2, screen-to-image downscale (640/4 = 160 columns, 480/4 = 120 visible rows)
ADDR_W, 15, RAM address width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
DrawX  in  10  current VGA column
DrawY  in  10  current VGA row
disp_en  in  1  VGA display enable (active pixel)
vblank  in  1  high during vertical blanking
frame_start  in  1  one-cycle pulse at start of each frame
scroll_en  in  1  advance scroll at frame_start
scroll_step  in  4  rows to advance per frame
bank_req  in  1  request displayed-bank change (one-cycle pulse)
bank_req_id  in  2  requested bank
wr_req  in  1  loader write request, level
wr_bank  in  2  loader target bank
wr_addr  in  15  loader address
wr_data  in  24  loader data
wr_ack  out  1  one-cycle pulse, write performed
we  out  4  one-hot per-bank write enable
write_address  out  15  shared RAM write address
data_In  out  24  shared RAM write data
read_address  out  15  shared RAM read address
bkg_sel  out  2  displayed bank, drives the RAM output mux
pix_in  in  24  data_Out of the selected bank
pix_out  out  24  registered background pixel
pix_valid  out  1  pix_out is valid

Behaviour:
- Reset: all outputs 0, scroll_row 0, bkg_sel 0, pending-bank flag clear, write FSM IDLE. A Reset asserted during WRITE drops we/wr_ack on the next edge; that write is not re-issued.
- Scroll: scroll_row in [0, IMG_H-1]. On frame_start with scroll_en=1: scroll_row <= scroll_row + scroll_step, minus IMG_H if the sum is >= IMG_H. Use an 8-bit intermediate. scroll_step=0 holds the value.
- Address (stage 1, registered): row = (DrawY>>SCALE_SHIFT) + scroll_row, wrapped mod IMG_H; col = DrawX>>SCALE_SHIFT; read_address <= row*IMG_W + col (maximum 25599).
- Stage 2: RAM produces pix_in, 1-cycle read latency.
- Stage 3: pix_out <= pix_in when the delayed disp_en is 1, else 0.
- Latency: DrawX/DrawY/disp_en to pix_out/pix_valid is exactly 3 cycles. pix_valid is disp_en delayed 3 cycles.
- Bank select: bank_req latches bank_req_id into pending and sets the pending flag. At frame_start, if the flag is set: bkg_sel <= pending, scroll_row <= 0 (overrides the scroll increment), flag cleared.
  - A bank_req in the same cycle as frame_start is applied at that frame_start.
  - A later bank_req before frame_start overwrites pending.
  - bkg_sel changes only on frame_start.
- Write FSM, states IDLE and WRITE:
  - eligible = wr_req && (vblank || (wr_bank != bkg_sel && !(pending_flag && wr_bank == pending))).
  - IDLE: if eligible, go to WRITE and register wr_addr/wr_data/wr_bank.
  - WRITE (1 cycle): we[wr_bank]=1, write_address, data_In and wr_ack=1; next state IDLE unconditionally.
  - Throughput is at most one write per 2 cycles. The loader holds its inputs stable until it sees wr_ack.
  - we is 0 in IDLE. write_address/data_In hold their last values.
- Reads and writes use separate RAM ports, so a write and a read to the same address may occur in the same cycle; read-during-write returns old data.

Optional Feature:
BKG_SCROLL_CLAMP_EN
- Defined: no wrap. scroll_row saturates at IMG_H - (480>>SCALE_SHIFT) = 40. The row sum never exceeds IMG_H-1, so the mod-IMG_H wrap logic is omitted.
- Undefined: wrap-around scroll as described in Behaviour.

Test Plan:
- Reset, then DrawX=0, DrawY=0, disp_en=1, scroll_row=0 -> read_address=0 after 1 cycle; pix_out=mem[0] and pix_valid=1 exactly 3 cycles after input.
- scroll_row=150, DrawY=40 (row 10), DrawX=8 -> wrapped row (10+150)-160=0, read_address=2. With BKG_SCROLL_CLAMP_EN, after 20 frames of scroll_step=3 -> scroll_row=40.
- scroll_step=7, 23 frame_start pulses from 0 -> scroll_row=161 mod 160=1. scroll_en=0 -> value holds.
- bank_req id=2 mid-frame -> bkg_sel stays 0 until next frame_start, then 2 and scroll_row=0. bank_req same cycle as frame_start -> applied that cycle.
- wr_req bank=0 while bkg_sel=0, vblank=0 -> no ack. vblank rises -> we=4'b0001, wr_ack one cycle later, one pulse only. wr_req bank=3 while bkg_sel=0 -> ack during active video.
- wr_req to the pending bank outside vblank -> blocked; Reset asserted in WRITE cycle -> we=0 next cycle, FSM IDLE.
